// File: rtl/fp32_pkg.sv
// ============================================================================
// Module   : fp32_pkg
// Brief    : Shared single-precision constants, number classification and
//            divider FSM state encoding for the FP unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fp32_pkg;

  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;
  localparam int FP_BIAS  = 127;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  typedef enum logic [1:0] {FP_ZERO, FP_NORM, FP_INF, FP_NAN} fp_class_t;

  typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} div_state_t;

  // exp==0 is classified as zero: denormals are flushed throughout the FP unit
  function automatic fp_class_t fp_class(input logic [31:0] x);
    fp_class_t c;
    if (x[30:23] == 8'h00) begin
      c = FP_ZERO;
    end else if (x[30:23] == 8'hFF) begin
      c = (x[22:0] != 23'h0) ? FP_NAN : FP_INF;
    end else begin
      c = FP_NORM;
    end
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fp_mant_div_step.sv
// ============================================================================
// Module   : fp_mant_div_step
// Brief    : One combinational restoring-division step on the mantissa
//            remainder; yields one quotient bit and the shifted remainder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_mant_div_step #(
  parameter int MAN_W = 23
) (
  input  logic [MAN_W+1:0] i_rem,
  input  logic [MAN_W:0]   i_mb,
  output logic [MAN_W+1:0] o_rem_next,
  output logic             o_qbit
);

  logic [MAN_W+1:0] w_mb_ext;
  logic [MAN_W+1:0] w_diff;
  logic [MAN_W+1:0] w_sel;

  assign w_mb_ext   = {1'b0, i_mb};
  assign o_qbit     = (i_rem >= w_mb_ext);
  assign w_diff     = i_rem - w_mb_ext;
  assign w_sel      = o_qbit ? w_diff : i_rem;
  // The kept remainder is always below mb, so the bit shifted out is zero
  assign o_rem_next = w_sel << 1;

endmodule

`default_nettype wire

// File: rtl/ieee754_divider_seq.sv
// ============================================================================
// Module   : ieee754_divider_seq
// Brief    : Iterative IEEE-754 single-precision divider, one quotient bit
//            per clock, start/busy/done handshake, truncating, FTZ.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ieee754_divider_seq
  import fp32_pkg::*;
#(
  parameter int EXP_W = FP_EXP_W,
  parameter int MAN_W = FP_MAN_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [EXP_W+MAN_W:0]     a,
  input  logic [EXP_W+MAN_W:0]     b,
  output logic                     busy,
  output logic                     done,
  output logic [EXP_W+MAN_W:0]     result
);

  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int Q_W   = MAN_W + 2;
  localparam int CNT_W = $clog2(Q_W);
  localparam logic [CNT_W-1:0] c_LAST_CNT  = CNT_W'(Q_W - 1);
  localparam logic [EXP_W+1:0] c_BIAS      = (EXP_W+2)'(FP_BIAS);
  localparam logic [EXP_W+1:0] c_BIAS_M1   = (EXP_W+2)'(FP_BIAS - 1);
  localparam logic [EXP_W:0]   c_EXP_MAX   = {1'b0, {EXP_W{1'b1}}};

  div_state_t          r_state;
  div_state_t          w_state_next;
  logic [CNT_W-1:0]    r_count;
  logic [MAN_W+1:0]    r_rem;
  logic [MAN_W:0]      r_mb;
  logic [Q_W-1:0]      r_q;
  logic                r_sign;
  logic [EXP_W-1:0]    r_ea;
  logic [EXP_W-1:0]    r_eb;
  logic [W-1:0]        r_result;
  logic                r_done;
  logic                r_busy;

  logic                w_accept;
  logic                w_special;
  logic [W-1:0]        w_spec_res;
  logic                w_sign;
  fp_class_t           w_ca;
  fp_class_t           w_cb;
  logic [MAN_W+1:0]    w_rem_next;
  logic                w_qbit;
  logic [EXP_W+1:0]    w_e;
  logic [MAN_W-1:0]    w_man;
  logic                w_ovf;
  logic                w_unf;
  logic [W-1:0]        w_norm_res;

  fp_mant_div_step #(
    .MAN_W (MAN_W)
  ) u_step (
    .i_rem      (r_rem),
    .i_mb       (r_mb),
    .o_rem_next (w_rem_next),
    .o_qbit     (w_qbit)
  );

  assign w_sign = a[W-1] ^ b[W-1];
  assign w_ca   = fp_class(a);
  assign w_cb   = fp_class(b);

  always_comb begin
    w_special  = 1'b1;
    w_spec_res = QNAN;
    if (w_ca == FP_NAN || w_cb == FP_NAN ||
        (w_ca == FP_ZERO && w_cb == FP_ZERO) ||
        (w_ca == FP_INF  && w_cb == FP_INF)) begin
      w_spec_res = QNAN;
    end else if (w_ca == FP_ZERO || w_cb == FP_INF) begin
      w_spec_res = {w_sign, {(W-1){1'b0}}};
    end else if (w_cb == FP_ZERO || w_ca == FP_INF) begin
      w_spec_res = {w_sign, POS_INF[W-2:0]};
    end else begin
      w_special  = 1'b0;
    end
  end

  // DONE lasts one cycle and is already free to take a new request
  assign w_accept = start && (r_state == IDLE || r_state == DONE);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_state_next = w_special ? DONE : DIV;
        end else begin
          w_state_next = IDLE;
        end
      end
      DIV:     w_state_next = (r_count == c_LAST_CNT) ? NORM : DIV;
      NORM:    w_state_next = DONE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Quotient of two values in [1,2) lies in (0.5,2): at most one left shift
  assign w_e   = {2'b00, r_ea} - {2'b00, r_eb} + (r_q[Q_W-1] ? c_BIAS : c_BIAS_M1);
  assign w_man = r_q[Q_W-1] ? r_q[MAN_W:1] : r_q[MAN_W-1:0];
  assign w_ovf = !w_e[EXP_W+1] && (w_e[EXP_W:0] >= c_EXP_MAX);
  assign w_unf = w_e[EXP_W+1] || (w_e == '0);

  always_comb begin
    w_norm_res = {r_sign, w_e[EXP_W-1:0], w_man};
    if (w_ovf) begin
      w_norm_res = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (w_unf) begin
      w_norm_res = {r_sign, {(W-1){1'b0}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count  <= '0;
      r_rem    <= '0;
      r_mb     <= '0;
      r_q      <= '0;
      r_sign   <= 1'b0;
      r_ea     <= '0;
      r_eb     <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_done <= (w_state_next == DONE);
      r_busy <= (w_state_next == DIV) || (w_state_next == NORM);
      if (w_accept) begin
        r_count <= '0;
        r_rem   <= {2'b01, a[MAN_W-1:0]};
        r_mb    <= {1'b1, b[MAN_W-1:0]};
        r_q     <= '0;
        r_sign  <= w_sign;
        r_ea    <= a[W-2:MAN_W];
        r_eb    <= b[W-2:MAN_W];
        if (w_special) begin
          r_result <= w_spec_res;
        end
      end else if (r_state == DIV) begin
        r_rem   <= w_rem_next;
        r_q     <= {r_q[Q_W-2:0], w_qbit};
        r_count <= r_count + 1'b1;
      end else if (r_state == NORM) begin
        r_result <= w_norm_res;
      end
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule

`default_nettype wire

// File: tb/tb_ieee754_divider_seq.sv
// ============================================================================
// Module   : tb_ieee754_divider_seq
// Brief    : Directed and reference-model checks for ieee754_divider_seq.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ieee754_divider_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_tests;
  int n_fail;

  ieee754_divider_seq dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Truncating reference: integer division of the scaled mantissas
  function automatic logic [31:0] ref_div(input logic [31:0] x, input logic [31:0] y);
    logic [47:0] num;
    logic [47:0] den;
    logic [47:0] q;
    int          e;
    logic [22:0] man;
    logic        s;
    s   = x[31] ^ y[31];
    num = {1'b1, x[22:0], 24'h0};
    den = {24'h0, 1'b1, y[22:0]};
    q   = num / den;
    if (q[24]) begin
      man = q[23:1];
      e   = int'(x[30:23]) - int'(y[30:23]) + 127;
    end else begin
      man = q[22:0];
      e   = int'(x[30:23]) - int'(y[30:23]) + 126;
    end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0)   return {s, 31'h0};
    return {s, e[7:0], man};
  endfunction

  // Drives a request at the current (negedge) time; returns at the negedge of the done cycle
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input int poke_at,
                        input int rst_at, output int lat, output int bcnt, output logic aborted);
    a       = ta;
    b       = tb_v;
    start   = 1'b1;
    lat     = 0;
    bcnt    = 0;
    aborted = 1'b0;
    @(posedge clk);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (n == poke_at) begin
        start = 1'b1;
        a     = 32'h3F80_0000;
        b     = 32'h4040_0000;
      end
      if (n == poke_at + 2) start = 1'b0;
      if (n == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        aborted = 1'b1;
        break;
      end
      if (busy) bcnt++;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  logic [31:0] sp_a [6];
  logic [31:0] sp_b [6];
  logic [31:0] sp_r [6];

  initial begin
    int          lat;
    int          bcnt;
    logic        ab;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        dseen;

    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    start   = 1'b0;
    a       = 32'h0;
    b       = 32'h0;

    sp_a = '{32'h4000_0000, 32'h0000_0000, 32'h0000_0000, 32'h7F80_0000, 32'h3F80_0000, 32'h7FC0_0000};
    sp_b = '{32'h0000_0000, 32'h0000_0000, 32'h4000_0000, 32'h3F80_0000, 32'h7F80_0000, 32'h3F80_0000};
    sp_r = '{32'h7F80_0000, 32'h7FC0_0000, 32'h0000_0000, 32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000};

    repeat (3) @(negedge clk);
    check("reset_busy", {31'h0, busy}, 32'd0);
    check("reset_done", {31'h0, done}, 32'd0);
    check("reset_result", result, 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 6/2
    run_op(32'h40C0_0000, 32'h4000_0000, 0, 0, lat, bcnt, ab);
    check("6div2_result", result, 32'h4040_0000);
    check("6div2_latency", 32'(lat), 32'd27);
    check("6div2_busy_cycles", 32'(bcnt), 32'd26);
    @(negedge clk);
    check("done_one_pulse", {31'h0, done}, 32'd0);
    check("result_held", result, 32'h4040_0000);
    @(negedge clk);

    // 1/3, then a second op started in the done cycle
    run_op(32'h3F80_0000, 32'h4040_0000, 0, 0, lat, bcnt, ab);
    check("1div3_result", result, 32'h3EAA_AAAA);
    check("1div3_latency", 32'(lat), 32'd27);
    run_op(32'hC100_0000, 32'h3F00_0000, 0, 0, lat, bcnt, ab);
    check("b2b_neg8div0p5_result", result, 32'hC180_0000);
    check("b2b_latency", 32'(lat), 32'd27);
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_op(sp_a[i], sp_b[i], 0, 0, lat, bcnt, ab);
      check($sformatf("special%0d_result", i), result, sp_r[i]);
      check($sformatf("special%0d_latency", i), 32'(lat), 32'd1);
      @(negedge clk);
    end

    run_op(32'h7F00_0000, 32'h3E80_0000, 0, 0, lat, bcnt, ab);
    check("overflow_result", result, 32'h7F80_0000);
    @(negedge clk);
    run_op(32'h0080_0000, 32'h4B00_0000, 0, 0, lat, bcnt, ab);
    check("underflow_result", result, 32'h0000_0000);
    @(negedge clk);

    // start pulsed mid-divide with different operands must be ignored
    run_op(32'h40C0_0000, 32'h4000_0000, 5, 0, lat, bcnt, ab);
    check("ignore_start_result", result, 32'h4040_0000);
    check("ignore_start_latency", 32'(lat), 32'd27);
    @(negedge clk);
    check("ignore_start_no_extra_busy", {31'h0, busy}, 32'd0);
    @(negedge clk);

    // reset during DIV aborts the operation
    run_op(32'h3F80_0000, 32'h4040_0000, 0, 10, lat, bcnt, ab);
    check("abort_taken", {31'h0, ab}, 32'd1);
    check("abort_busy", {31'h0, busy}, 32'd0);
    check("abort_done", {31'h0, done}, 32'd0);
    check("abort_result", result, 32'h0);
    dseen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) dseen = 1'b1;
    end
    check("abort_no_done", {31'h0, dseen}, 32'd0);
    run_op(32'h40C0_0000, 32'h4000_0000, 0, 0, lat, bcnt, ab);
    check("after_abort_result", result, 32'h4040_0000);
    check("after_abort_latency", 32'(lat), 32'd27);
    @(negedge clk);

    for (int i = 0; i < 200; i++) begin
      ra = {1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)), 23'($urandom)};
      rb = {1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)), 23'($urandom)};
      run_op(ra, rb, 0, 0, lat, bcnt, ab);
      check($sformatf("rand%0d_%h_%h", i, ra, rb), result, ref_div(ra, rb));
      check($sformatf("rand%0d_latency", i), 32'(lat), 32'd27);
      if (i % 3 == 0) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
